// File: rtl/ars_gf2m_mult_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ars_gf2m_mult_unit_if
// Description : Start/complete handshake bundle between a point-arithmetic
//               controller (master) and a GF(2^M) multiplier (slave).
//               IN_VALID/OP/A/B   : controller -> multiplier (start pulse)
//               Z/OUT_VALID       : multiplier -> controller (result pulse)
//               BUSY/IN_DROP      : multiplier status
// Revision    : 1.0 - initial release
// ============================================================================
interface ars_gf2m_mult_unit_if #(
    parameter int M = 163
);
    logic         IN_VALID;
    logic         OP;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic [M-1:0] Z;
    logic         OUT_VALID;
    logic         BUSY;
    logic         IN_DROP;

    modport master (
        output IN_VALID, OP, A, B,
        input  Z, OUT_VALID, BUSY, IN_DROP
    );

    modport slave (
        input  IN_VALID, OP, A, B,
        output Z, OUT_VALID, BUSY, IN_DROP
    );
endinterface
`default_nettype wire

// File: rtl/ars_gf2m_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : ars_gf2m_mult_unit
// Description : Digit-serial GF(2^M) polynomial-basis multiplier/squarer,
//               f(x) = x^M + POLY. Processes D bits of B per cycle, MSB digit
//               first (Horner), so a result takes ceil(M/D)+1 cycles.
// Ports       : CLK  - clock, rising edge
//               RST  - asynchronous active-high reset
//               bus  - slave side of the start/result handshake:
//                      IN_VALID/OP/A/B in, Z/OUT_VALID/BUSY/IN_DROP out
// Revision    : 1.0 - initial release
// ============================================================================
module ars_gf2m_mult_unit #(
    parameter int           M    = 163,
    parameter logic [M-1:0] POLY = 163'h0C9,
    parameter int           D    = 1
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    ars_gf2m_mult_unit_if.slave    bus
);

    localparam int c_N  = (M + D - 1) / D;
    localparam int c_NW = c_N * D;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      r_state_q,     w_state_d;
    logic [M-1:0]    r_ra_q,        w_ra_d;
    logic [c_NW-1:0] r_rb_q,        w_rb_d;
    logic [M-1:0]    r_acc_q,       w_acc_d;
    logic [c_CW-1:0] r_cnt_q,       w_cnt_d;
    logic [M-1:0]    r_z_q,         w_z_d;
    logic            r_out_valid_q, w_out_valid_d;
    logic            r_busy_q,      w_busy_d;
    logic            r_in_drop_q,   w_in_drop_d;

    logic [D-1:0]    w_digit;
    logic [D-1:0]    w_hi;
    logic [M-1:0]    w_acc_shift;
    logic [M-1:0]    w_pp;
    logic [M-1:0]    w_pp_term;
    logic [M-1:0]    w_acc_next;

    // Multiply by x with one reduction step.
    function automatic logic [M-1:0] f_mulx(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
    endfunction

    assign w_digit = r_rb_q[c_NW-1 -: D];
    assign w_hi    = r_acc_q[M-1 -: D];

    // One Horner step: C*x^D mod f  xor  Ra*digit mod f.
    // The D bits shifted out of C are folded back in a single pass as
    // h(x)*POLY; the degree bound on POLY keeps that fold below x^M.
    always_comb begin
        w_acc_shift = {r_acc_q[M-D-1:0], {D{1'b0}}};
        for (int j = 0; j < D; j++) begin
            if (w_hi[j]) begin
                w_acc_shift = w_acc_shift ^ (POLY << j);
            end
        end

        w_pp      = '0;
        w_pp_term = r_ra_q;
        for (int j = 0; j < D; j++) begin
            if (w_digit[j]) begin
                w_pp = w_pp ^ w_pp_term;
            end
            w_pp_term = f_mulx(w_pp_term);
        end

        w_acc_next = w_acc_shift ^ w_pp;
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_ra_d        = r_ra_q;
        w_rb_d        = r_rb_q;
        w_acc_d       = r_acc_q;
        w_cnt_d       = r_cnt_q;
        w_z_d         = r_z_q;
        w_out_valid_d = 1'b0;
        w_in_drop_d   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (bus.IN_VALID) begin
                    w_ra_d    = bus.A;
                    // Squaring is just A*A; B is zero-extended at the MSB end.
                    w_rb_d    = c_NW'(bus.OP ? bus.A : bus.B);
                    w_acc_d   = '0;
                    w_cnt_d   = c_LAST;
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_acc_d = w_acc_next;
                w_rb_d  = r_rb_q << D;
                if (bus.IN_VALID) begin
                    w_in_drop_d = 1'b1;
                end
                if (r_cnt_q == '0) begin
                    w_z_d         = w_acc_next;
                    w_out_valid_d = 1'b1;
                    w_state_d     = S_IDLE;
                end else begin
                    w_cnt_d = r_cnt_q - c_CW'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_busy_d = (w_state_d == S_RUN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q     <= S_IDLE;
            r_ra_q        <= '0;
            r_rb_q        <= '0;
            r_acc_q       <= '0;
            r_cnt_q       <= '0;
            r_z_q         <= '0;
            r_out_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_in_drop_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ra_q        <= w_ra_d;
            r_rb_q        <= w_rb_d;
            r_acc_q       <= w_acc_d;
            r_cnt_q       <= w_cnt_d;
            r_z_q         <= w_z_d;
            r_out_valid_q <= w_out_valid_d;
            r_busy_q      <= w_busy_d;
            r_in_drop_q   <= w_in_drop_d;
        end
    end

    assign bus.Z         = r_z_q;
    assign bus.OUT_VALID = r_out_valid_q;
    assign bus.BUSY      = r_busy_q;
    assign bus.IN_DROP   = r_in_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ars_gf2m_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ars_gf2m_mult_unit
// Description : Self-checking bench for ars_gf2m_mult_unit. Two instances on
//               the NIST-163 field: D=1 (main) and D=4 (digit-size check).
//               Expected results go into a queue at issue time and are popped
//               when OUT_VALID is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ars_gf2m_mult_unit;

    localparam int           M    = 163;
    localparam logic [M-1:0] POLY = 163'h0C9;
    localparam logic [M-1:0] ONE  = 163'h1;
    localparam logic [M-1:0] X1   = 163'h2;
    localparam logic [M-1:0] X162 = ONE << 162;
    localparam logic [M-1:0] X100 = ONE << 100;
    localparam logic [M-1:0] SQ_E = 163'h1920_0000_0000;
    localparam int           LIMIT = 400;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    logic [M-1:0] exp_q[$];

    ars_gf2m_mult_unit_if #(.M(M)) if1 ();
    ars_gf2m_mult_unit_if #(.M(M)) if4 ();

    ars_gf2m_mult_unit #(.M(M), .POLY(POLY), .D(1)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (if1)
    );

    ars_gf2m_mult_unit #(.M(M), .POLY(POLY), .D(4)) dut4 (
        .CLK (clk),
        .RST (rst),
        .bus (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: schoolbook carry-less product, then reduce top-down.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-1:0] p;
        logic [2*M-1:0] ae;
        p  = '0;
        ae = {{M{1'b0}}, a};
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ (ae << i);
        end
        for (int i = 2*M-2; i >= M; i--) begin
            if (p[i]) begin
                p[i] = 1'b0;
                p[i-M +: M] = p[i-M +: M] ^ POLY;
            end
        end
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rand_elem();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[M-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue1(input logic op, input logic [M-1:0] a, input logic [M-1:0] b);
        if1.IN_VALID = 1'b1;
        if1.OP       = op;
        if1.A        = a;
        if1.B        = b;
        tick();
        if1.IN_VALID = 1'b0;
        if1.A        = rand_elem();
        if1.B        = rand_elem();
    endtask

    // Advance until dut1 shows OUT_VALID; lat counts cycles since IN_VALID.
    task automatic wait_out1(input int start, output int lat, output int busy_n, output int drop_n);
        lat    = start;
        busy_n = 0;
        drop_n = 0;
        while (!if1.OUT_VALID && lat < LIMIT) begin
            if (if1.BUSY)    busy_n++;
            if (if1.IN_DROP) drop_n++;
            tick();
            lat++;
        end
    endtask

    task automatic pop_exp(output logic [M-1:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (if1.Z !== '0)        begin n_fail++; $display("FAIL reset_z got=%h exp=0", if1.Z); end
        n_checks++; if (if1.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", if1.OUT_VALID); end
        n_checks++; if (if1.BUSY !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b exp=0", if1.BUSY); end
        n_checks++; if (if1.IN_DROP !== 1'b0) begin n_fail++; $display("FAIL reset_in_drop got=%b exp=0", if1.IN_DROP); end
        n_checks++; if (if4.BUSY !== 1'b0 || if4.Z !== '0) begin n_fail++; $display("FAIL reset_d4 busy=%b z=%h exp 0/0", if4.BUSY, if4.Z); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        int lat, bn, dn;
        logic [M-1:0] e;
        exp_q.push_back(ONE);
        issue1(1'b0, ONE, ONE);
        wait_out1(1, lat, bn, dn);
        pop_exp(e);
        n_checks++; if (lat !== 164) begin n_fail++; $display("FAIL identity_latency got=%0d exp=164", lat); end
        n_checks++; if (bn !== 163)  begin n_fail++; $display("FAIL identity_busy_cycles got=%0d exp=163", bn); end
        n_checks++; if (if1.Z !== e) begin n_fail++; $display("FAIL identity_z got=%h exp=%h", if1.Z, e); end
        n_checks++; if (if1.BUSY !== 1'b0) begin n_fail++; $display("FAIL identity_busy_at_done got=%b exp=0", if1.BUSY); end
        tick();
        n_checks++; if (if1.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL identity_pulse_width got=%b exp=0", if1.OUT_VALID); end
        n_checks++; if (if1.Z !== ONE) begin n_fail++; $display("FAIL identity_z_hold got=%h exp=1", if1.Z); end
    endtask

    task automatic test_reduction();
        int lat, bn, dn;
        logic [M-1:0] e;
        exp_q.push_back(163'h0C9);
        issue1(1'b0, X162, X1);
        wait_out1(1, lat, bn, dn);
        pop_exp(e);
        n_checks++; if (lat !== 164) begin n_fail++; $display("FAIL reduction_latency got=%0d exp=164", lat); end
        n_checks++; if (if1.Z !== e) begin n_fail++; $display("FAIL reduction_z got=%h exp=%h", if1.Z, e); end
        tick();
    endtask

    task automatic test_reduction_d4();
        int lat;
        logic [M-1:0] e;
        exp_q.push_back(163'h0C9);
        if4.IN_VALID = 1'b1;
        if4.OP       = 1'b0;
        if4.A        = X162;
        if4.B        = X1;
        tick();
        if4.IN_VALID = 1'b0;
        lat = 1;
        while (!if4.OUT_VALID && lat < LIMIT) begin
            tick();
            lat++;
        end
        pop_exp(e);
        n_checks++; if (lat !== 42)  begin n_fail++; $display("FAIL d4_latency got=%0d exp=42", lat); end
        n_checks++; if (if4.Z !== e) begin n_fail++; $display("FAIL d4_z got=%h exp=%h", if4.Z, e); end
        tick();
        // A few random products on the D=4 datapath.
        for (int k = 0; k < 3; k++) begin
            logic [M-1:0] a, b;
            a = rand_elem();
            b = rand_elem();
            exp_q.push_back(gf_mul(a, b));
            if4.IN_VALID = 1'b1;
            if4.A = a;
            if4.B = b;
            tick();
            if4.IN_VALID = 1'b0;
            lat = 1;
            while (!if4.OUT_VALID && lat < LIMIT) begin
                tick();
                lat++;
            end
            pop_exp(e);
            n_checks++; if (lat !== 42 || if4.Z !== e) begin n_fail++; $display("FAIL d4_random lat=%0d z=%h exp lat=42 z=%h", lat, if4.Z, e); end
            tick();
        end
    endtask

    task automatic test_square();
        int lat, bn, dn;
        logic [M-1:0] e, a;
        exp_q.push_back(SQ_E);
        issue1(1'b1, X100, 163'h5A5A);
        wait_out1(1, lat, bn, dn);
        pop_exp(e);
        n_checks++; if (lat !== 164 || if1.Z !== e) begin n_fail++; $display("FAIL square_z lat=%0d got=%h exp lat=164 z=%h", lat, if1.Z, e); end
        tick();
        a = rand_elem();
        exp_q.push_back(gf_mul(a, a));
        issue1(1'b1, a, rand_elem());
        wait_out1(1, lat, bn, dn);
        pop_exp(e);
        n_checks++; if (if1.Z !== e) begin n_fail++; $display("FAIL square_random got=%h exp=%h", if1.Z, e); end
        tick();
    endtask

    task automatic test_random_mul();
        int lat, bn, dn;
        logic [M-1:0] e, a, b;
        for (int k = 0; k < 4; k++) begin
            a = rand_elem();
            b = rand_elem();
            exp_q.push_back(gf_mul(a, b));
            issue1(1'b0, a, b);
            wait_out1(1, lat, bn, dn);
            pop_exp(e);
            n_checks++; if (lat !== 164 || if1.Z !== e) begin n_fail++; $display("FAIL random_mul lat=%0d got=%h exp lat=164 z=%h", lat, if1.Z, e); end
            tick();
        end
    endtask

    task automatic test_busy_collision();
        int lat, bn, dn;
        logic [M-1:0] e;
        exp_q.push_back(163'hF);
        issue1(1'b0, 163'h3, 163'h5);
        for (int k = 0; k < 9; k++) tick();
        if1.IN_VALID = 1'b1;
        if1.A        = 163'h7;
        if1.B        = 163'h7;
        tick();
        if1.IN_VALID = 1'b0;
        n_checks++; if (if1.IN_DROP !== 1'b1) begin n_fail++; $display("FAIL collision_drop_now got=%b exp=1", if1.IN_DROP); end
        wait_out1(11, lat, bn, dn);
        pop_exp(e);
        n_checks++; if (dn !== 1)    begin n_fail++; $display("FAIL collision_drop_count got=%0d exp=1", dn); end
        n_checks++; if (lat !== 164) begin n_fail++; $display("FAIL collision_latency got=%0d exp=164", lat); end
        n_checks++; if (if1.Z !== e) begin n_fail++; $display("FAIL collision_z got=%h exp=%h", if1.Z, e); end
        tick();
        n_checks++; if (if1.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL collision_extra_out got=%b exp=0", if1.OUT_VALID); end
    endtask

    task automatic test_back_to_back();
        int lat, bn, dn;
        logic [M-1:0] e;
        exp_q.push_back(ONE);
        issue1(1'b0, ONE, ONE);
        wait_out1(1, lat, bn, dn);
        pop_exp(e);
        n_checks++; if (if1.Z !== e) begin n_fail++; $display("FAIL b2b_first_z got=%h exp=%h", if1.Z, e); end
        exp_q.push_back(163'h0C9);
        issue1(1'b0, X162, X1);
        wait_out1(1, lat, bn, dn);
        pop_exp(e);
        n_checks++; if (lat !== 164) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=164", lat); end
        n_checks++; if (if1.Z !== e) begin n_fail++; $display("FAIL b2b_second_z got=%h exp=%h", if1.Z, e); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int lat, bn, dn, outs;
        logic [M-1:0] e;
        issue1(1'b0, 163'h5, 163'h9);
        for (int k = 0; k < 49; k++) tick();
        n_checks++; if (if1.Z !== 163'h0C9 || if1.BUSY !== 1'b1) begin n_fail++; $display("FAIL midop_pre z=%h busy=%b exp z=c9 busy=1", if1.Z, if1.BUSY); end
        rst = 1'b1;
        #1;
        n_checks++; if (if1.Z !== '0)       begin n_fail++; $display("FAIL midop_async_z got=%h exp=0", if1.Z); end
        n_checks++; if (if1.BUSY !== 1'b0)  begin n_fail++; $display("FAIL midop_async_busy got=%b exp=0", if1.BUSY); end
        tick();
        tick();
        rst  = 1'b0;
        outs = 0;
        for (int k = 0; k < 200; k++) begin
            if (if1.OUT_VALID) outs++;
            tick();
        end
        n_checks++; if (outs !== 0) begin n_fail++; $display("FAIL midop_no_out got=%0d exp=0", outs); end
        exp_q.push_back(ONE);
        issue1(1'b0, ONE, ONE);
        wait_out1(1, lat, bn, dn);
        pop_exp(e);
        n_checks++; if (lat !== 164 || if1.Z !== e) begin n_fail++; $display("FAIL midop_recover lat=%0d got=%h exp lat=164 z=%h", lat, if1.Z, e); end
        tick();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        if1.IN_VALID = 1'b0;
        if1.OP       = 1'b0;
        if1.A        = '0;
        if1.B        = '0;
        if4.IN_VALID = 1'b0;
        if4.OP       = 1'b0;
        if4.A        = '0;
        if4.B        = '0;
        #1;
        test_reset();
        test_identity();
        test_reduction();
        test_reduction_d4();
        test_square();
        test_random_mul();
        test_busy_collision();
        test_back_to_back();
        test_reset_mid_op();
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
